stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Operand-stack controller for the stack processor: owns the data stack, executes push/pop/dup/swap/over/replace commands issued by the core sequencer, and reports depth and fault status. Top-of-stack (TOS) and next-on-stack (NOS) are held in registers. Deeper entries spill to a single-port, synchronous-read stack RAM inside the block. It sits between the instruction decoder/ALU and the stack storage, and its `tos`/`nos` outputs feed the ALU operands directly.

## Interface
- `WIDTH`, 16: data word width.
- `DEPTH`, 16: total stack capacity in words (TOS + NOS + `DEPTH-2` RAM entries); must be ≥ 4.
- `CLK`  in  1  rising-edge clock, the only clock.
- `RST`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_op`  in  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 OVER, 6 REPLACE, 7 illegal.
- `cmd_data`  in  WIDTH  operand for PUSH/REPLACE.
- `rsp_valid`  out  1  one-cycle pulse: popped word on `rsp_data`.
- `rsp_data`  out  WIDTH  value removed by POP.
- `tos`, `nos`  out  WIDTH  current top and second entries (0 when absent).
- `depth`  out  $clog2(DEPTH+1)  number of valid entries.
- `empty`, `full`  out  1  depth==0 / depth==DEPTH.
- `err_overflow`, `err_underflow`, `err_illegal`  out  1  sticky fault flags.

## Operation
- Accept = `cmd_valid && cmd_ready`. `cmd_ready` = (state==IDLE) && !RST.
- FSM states: IDLE, REFILL. REFILL is entered only by an accepted POP with depth≥3. It lasts exactly one cycle and then returns to IDLE.
- RAM spill slot is index depth-3. A RAM write occurs on any push-class op when depth≥2.
- PUSH: nos→RAM (if depth≥2), tos→nos, cmd_data→tos, depth+1.
- DUP: same as PUSH with the old tos as the pushed value; requires depth≥1.
- OVER: same as PUSH with the old nos as the pushed value; requires depth≥2.
- POP: rsp_data←tos, rsp_valid pulses in the accept cycle's following cycle, tos←nos, depth−1.
  - If depth≥3: the RAM read of index depth-3 is issued at accept; nos←RAM data at end of REFILL.
  - Otherwise nos←0 immediately.
- SWAP: requires depth≥2; tos↔nos, no RAM access.
- REPLACE: requires depth≥1; tos←cmd_data.
- NOP: no effect.
- Faults:
  - PUSH, DUP, or OVER at depth==DEPTH sets `err_overflow`.
  - POP, DUP, or REPLACE at depth 0, or SWAP or OVER at depth<2, sets `err_underflow`.
  - op 7 sets `err_illegal`.
  - A faulting command is still accepted, but changes no stack state and produces no `rsp_valid`.
  - Fault flags stay set until RST.
- Entries not covered by depth read as 0 on `tos`/`nos`. RAM contents are don't-care.

## Timing
- Reset values (after an RST cycle): state IDLE, `tos`=0, `nos`=0, `depth`=0, `empty`=1, `full`=0, all err=0, `rsp_valid`=0, `rsp_data`=0. `cmd_ready`=0 while RST is high and 1 in the first cycle after.
- All outputs are registered except `cmd_ready`. State updates are visible the cycle after accept.
- Throughput:
  - Every op except POP at depth≥3 takes 1 command/cycle.
  - POP at depth≥3 holds `cmd_ready` low for one cycle, so back-to-back deep POPs run at 1 per 2 cycles.
- During REFILL, `tos` and `depth` already show their post-POP values. `nos` shows its stale value until the end of REFILL.
- RST asserted in REFILL aborts the refill and applies reset values next cycle.
- `full` and `empty` are updated in the same cycle as `depth`.

## Test plan
- Reset: assert RST 2 cycles with cmd_valid=1, op PUSH -> no accept, depth=0, empty=1, cmd_ready=0 then 1.
- Fill/drain: PUSH 1..16 back-to-back -> depth=16, full=1, tos=16, nos=15, cmd_ready always 1. Then 16 POPs -> rsp_data 16,15,...,1. `cmd_ready` low one cycle after each POP while depth≥3. Ends with empty=1, tos=nos=0.
- Overflow/underflow: PUSH at full -> err_overflow=1, depth stays 16, tos unchanged. POP at empty -> err_underflow=1, no rsp_valid. Both flags persist until RST.
- Stack ops: push 5,7 then SWAP -> tos=5,nos=7. OVER -> tos=7,nos=5,depth=3. DUP -> tos=7,depth=4. REPLACE 9 -> tos=9. POP×4 -> rsp 9,7,5,7.
- Illegal/short ops: op 7 -> err_illegal=1, no state change. SWAP at depth 1 -> err_underflow=1, tos unchanged.
- Reset mid-REFILL: depth 5, POP, assert RST in REFILL cycle -> next cycle all reset values, state IDLE, no rsp_valid after reset.

Source files
------------

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - operand-stack controller with register TOS/NOS and RAM spill
//
// Holds the top two stack entries in registers and spills deeper entries to
// a single-port, synchronous-read RAM. A POP that has to pull the next entry
// back from RAM spends one REFILL cycle waiting for the read data.
//
// Ports:
//   CLK, RST        clock and synchronous active-high reset
//   cmd_valid/ready command handshake; cmd_op selects the operation
//   cmd_data        operand for PUSH / REPLACE
//   rsp_valid/data  one-cycle pulse carrying the word removed by POP
//   tos, nos        top and second entries (0 when absent)
//   depth           number of valid entries; empty / full derived from it
//   err_*           sticky overflow / underflow / illegal-op flags
module stack_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_data,
  output logic                       rsp_valid,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       err_overflow,
  output logic                       err_underflow,
  output logic                       err_illegal
);

  localparam int DW    = $clog2(DEPTH+1);
  localparam int RAM_N = DEPTH - 2;
  localparam int AW    = (RAM_N > 1) ? $clog2(RAM_N) : 1;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_DUP     = 3'd3;
  localparam logic [2:0] OP_SWAP    = 3'd4;
  localparam logic [2:0] OP_OVER    = 3'd5;
  localparam logic [2:0] OP_REPLACE = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic {ST_IDLE = 1'b0, ST_REFILL = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_tos;
  logic [WIDTH-1:0] r_nos;
  logic [DW-1:0]    r_depth;
  logic             r_empty;
  logic             r_full;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_err_ovf;
  logic             r_err_udf;
  logic             r_err_ill;
  logic [WIDTH-1:0] r_mem [RAM_N];
  logic [WIDTH-1:0] r_rdata;

  logic             w_acc;
  logic             w_is_push;
  logic             w_ovf;
  logic             w_udf;
  logic             w_ill;
  logic             w_do;
  logic             w_spill;
  logic             w_fill;
  logic [WIDTH-1:0] w_push_val;
  logic [DW-1:0]    w_depth_nxt;
  logic [AW-1:0]    w_addr;

  assign cmd_ready = (r_state == ST_IDLE) && !RST;
  assign w_acc     = cmd_valid && cmd_ready;

  always_comb begin
    w_is_push  = (cmd_op == OP_PUSH) || (cmd_op == OP_DUP) || (cmd_op == OP_OVER);
    w_ovf      = w_is_push && (r_depth == DW'(DEPTH));
    w_udf      = (((cmd_op == OP_POP) || (cmd_op == OP_DUP) || (cmd_op == OP_REPLACE))
                  && (r_depth == '0))
              || (((cmd_op == OP_SWAP) || (cmd_op == OP_OVER)) && (r_depth < DW'(2)));
    w_ill      = (cmd_op == OP_ILLEGAL);
    // A faulting command is consumed but leaves the stack untouched.
    w_do       = w_acc && !(w_ovf || w_udf || w_ill);
    w_spill    = w_do && w_is_push && (r_depth >= DW'(2));
    w_fill     = w_do && (cmd_op == OP_POP) && (r_depth >= DW'(3));

    w_push_val = cmd_data;
    if (cmd_op == OP_DUP)  w_push_val = r_tos;
    if (cmd_op == OP_OVER) w_push_val = r_nos;

    w_depth_nxt = r_depth;
    if (w_do && w_is_push)          w_depth_nxt = r_depth + DW'(1);
    if (w_do && (cmd_op == OP_POP)) w_depth_nxt = r_depth - DW'(1);

    // Spill writes land at (new depth - 3); refill reads come from (old depth - 3).
    w_addr = w_spill ? AW'(r_depth - DW'(2)) : AW'(r_depth - DW'(3));
  end

  // Single-port RAM: spill and refill never coincide since a POP is not a push.
  always_ff @(posedge CLK) begin
    if (w_spill) r_mem[w_addr] <= r_nos;
    if (w_fill)  r_rdata <= r_mem[w_addr];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_tos       <= '0;
      r_nos       <= '0;
      r_depth     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_err_ovf   <= 1'b0;
      r_err_udf   <= 1'b0;
      r_err_ill   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_depth     <= w_depth_nxt;
      r_empty     <= (w_depth_nxt == '0);
      r_full      <= (w_depth_nxt == DW'(DEPTH));
      case (r_state)
        ST_REFILL: begin
          r_nos   <= r_rdata;
          r_state <= ST_IDLE;
        end
        default: begin
          if (w_acc) begin
            if (w_ovf) r_err_ovf <= 1'b1;
            if (w_udf) r_err_udf <= 1'b1;
            if (w_ill) r_err_ill <= 1'b1;
          end
          if (w_do) begin
            case (cmd_op)
              OP_PUSH, OP_DUP, OP_OVER: begin
                r_nos <= r_tos;
                r_tos <= w_push_val;
              end
              OP_POP: begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= r_tos;
                r_tos       <= r_nos;
                if (r_depth >= DW'(3)) r_state <= ST_REFILL;
                else                   r_nos   <= '0;
              end
              OP_SWAP: begin
                r_tos <= r_nos;
                r_nos <= r_tos;
              end
              OP_REPLACE: r_tos <= cmd_data;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign tos           = r_tos;
  assign nos           = r_nos;
  assign depth         = r_depth;
  assign empty         = r_empty;
  assign full          = r_full;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_udf;
  assign err_illegal   = r_err_ill;

  logic w_unused;
  assign w_unused = ^{OP_NOP};

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed self-checking bench for stack_ctrl
module tb_stack_ctrl;

  logic        CLK;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] tos;
  logic [15:0] nos;
  logic [4:0]  depth;
  logic        empty;
  logic        full;
  logic        err_overflow;
  logic        err_underflow;
  logic        err_illegal;

  int n_tests;
  int n_fail;

  stack_ctrl #(.WIDTH(16), .DEPTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tos(tos), .nos(nos), .depth(depth),
    .empty(empty), .full(full),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_illegal(err_illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one command for one edge; outputs are then sampled 1 time unit after.
  task automatic issue(input logic [2:0] op, input logic [15:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 4 && !cmd_ready; k++) tick();
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cmd_valid = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    RST       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_data  = 16'h00aa;

    // Reset held two cycles with a PUSH offered
    tick();
    tick();
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_depth", 32'(depth), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_tos", 32'(tos), 0);
    check("rst_nos", 32'(nos), 0);
    check("rst_rsp", 32'({rsp_valid, rsp_data}), 0);
    check("rst_err", 32'({err_overflow, err_underflow, err_illegal}), 0);
    RST = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("rst_ready_after", 32'(cmd_ready), 1);

    // Fill 1..16 back-to-back
    for (int i = 1; i <= 16; i++) begin
      check("fill_ready", 32'(cmd_ready), 1);
      issue(3'd1, 16'(i));
    end
    check("fill_depth", 32'(depth), 16);
    check("fill_full", 32'(full), 1);
    check("fill_empty", 32'(empty), 0);
    check("fill_tos", 32'(tos), 16);
    check("fill_nos", 32'(nos), 15);

    // Drain 16..1
    for (int i = 16; i >= 1; i--) begin
      issue(3'd2, 16'h0);
      check("drain_rsp_valid", 32'(rsp_valid), 1);
      check("drain_rsp_data", 32'(rsp_data), 32'(i));
      check("drain_depth", 32'(depth), 32'(i - 1));
      check("drain_tos", 32'(tos), 32'(i - 1));
      if (i >= 3) begin
        check("drain_refill_ready", 32'(cmd_ready), 0);
        check("drain_nos_stale", 32'(nos), 32'(i - 1));
        tick();
        check("drain_rsp_pulse", 32'(rsp_valid), 0);
        check("drain_nos", 32'(nos), 32'(i - 2));
      end else begin
        check("drain_ready", 32'(cmd_ready), 1);
        check("drain_nos", 32'(nos), 0);
      end
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_full", 32'(full), 0);
    check("drain_tos0", 32'(tos), 0);
    check("drain_nos0", 32'(nos), 0);

    // Overflow at full, underflow at empty
    for (int i = 1; i <= 16; i++) issue(3'd1, 16'(100 + i));
    issue(3'd1, 16'h0055);
    check("ovf_flag", 32'(err_overflow), 1);
    check("ovf_depth", 32'(depth), 16);
    check("ovf_tos", 32'(tos), 116);
    check("ovf_nos", 32'(nos), 115);
    for (int i = 16; i >= 1; i--) begin
      wait_ready();
      issue(3'd2, 16'h0);
      check("ovf_drain_data", 32'(rsp_data), 32'(100 + i));
    end
    wait_ready();
    issue(3'd2, 16'h0);
    check("udf_flag", 32'(err_underflow), 1);
    check("udf_no_rsp", 32'(rsp_valid), 0);
    check("udf_depth", 32'(depth), 0);
    issue(3'd0, 16'h0);
    check("sticky_ovf", 32'(err_overflow), 1);
    check("sticky_udf", 32'(err_underflow), 1);
    do_reset();
    check("clr_err", 32'({err_overflow, err_underflow, err_illegal}), 0);

    // Stack ops
    issue(3'd1, 16'd5);
    issue(3'd1, 16'd7);
    issue(3'd4, 16'h0);
    check("swap_tos", 32'(tos), 5);
    check("swap_nos", 32'(nos), 7);
    issue(3'd5, 16'h0);
    check("over_tos", 32'(tos), 7);
    check("over_nos", 32'(nos), 5);
    check("over_depth", 32'(depth), 3);
    issue(3'd3, 16'h0);
    check("dup_tos", 32'(tos), 7);
    check("dup_nos", 32'(nos), 7);
    check("dup_depth", 32'(depth), 4);
    issue(3'd6, 16'd9);
    check("repl_tos", 32'(tos), 9);
    check("repl_depth", 32'(depth), 4);
    begin
      logic [15:0] exp_pop [4];
      exp_pop = '{16'd9, 16'd7, 16'd5, 16'd7};
      for (int i = 0; i < 4; i++) begin
        wait_ready();
        issue(3'd2, 16'h0);
        check("ops_pop_valid", 32'(rsp_valid), 1);
        check("ops_pop_data", 32'(rsp_data), 32'(exp_pop[i]));
      end
    end
    check("ops_empty", 32'(empty), 1);
    check("ops_no_err", 32'({err_overflow, err_underflow, err_illegal}), 0);

    // Illegal op and short SWAP
    issue(3'd1, 16'd3);
    issue(3'd7, 16'h1234);
    check("ill_flag", 32'(err_illegal), 1);
    check("ill_depth", 32'(depth), 1);
    check("ill_tos", 32'(tos), 3);
    check("ill_udf_clear", 32'(err_underflow), 0);
    issue(3'd4, 16'h0);
    check("swap1_udf", 32'(err_underflow), 1);
    check("swap1_tos", 32'(tos), 3);
    check("swap1_nos", 32'(nos), 0);

    // Reset during REFILL
    do_reset();
    for (int i = 1; i <= 5; i++) issue(3'd1, 16'(i));
    issue(3'd2, 16'h0);
    check("mid_in_refill", 32'(cmd_ready), 0);
    check("mid_rsp", 32'(rsp_data), 5);
    RST = 1'b1;
    #1;
    check("mid_ready_rst", 32'(cmd_ready), 0);
    tick();
    RST = 1'b0;
    #1;
    check("mid_tos", 32'(tos), 0);
    check("mid_nos", 32'(nos), 0);
    check("mid_depth", 32'(depth), 0);
    check("mid_empty", 32'(empty), 1);
    check("mid_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rsp_data", 32'(rsp_data), 0);
    check("mid_ready", 32'(cmd_ready), 1);
    tick();
    check("mid_after_rsp", 32'(rsp_valid), 0);
    check("mid_after_nos", 32'(nos), 0);
    check("mid_after_depth", 32'(depth), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
